mult_seq: RTL and testbench
===========================

// Module: mult_seq
// PURPOSE
//  Sequential signed multiplier (radix-2 Booth), the multiply counterpart of the combinational divider
//  in the multicycle MIPS datapath. Serves MULT: 32x32 signed -> 64-bit product split into HI/LO.
//  Control unit pulses start, stalls on busy, then writes MultHI/MultLO into the HI/LO registers on done.
//  One Booth step per clock; no combinational 32x32 multiplier array.
// PARAMETERS
//  WIDTH   32   operand width; product is 2*WIDTH, split into HI (upper) and LO (lower) words
// PORTS
//  clk        in   1        rising-edge clock
//  reset_n    in   1        synchronous reset, active-low
//  Multstart  in   1        request; sampled only in IDLE
//  Multsrca   in   WIDTH    multiplicand M, two's complement
//  Multsrcb   in   WIDTH    multiplier Q, two's complement
//  MultHI     out  WIDTH    product[2*WIDTH-1:WIDTH]
//  MultLO     out  WIDTH    product[WIDTH-1:0]
//  Multbusy   out  1        high in RUN and DONE
//  Multdone   out  1        one-cycle pulse: MultHI/MultLO valid
// BEHAVIOUR
//  Reset (reset_n=0 at a clk edge): state=IDLE, count=0, internal regs=0; MultHI=0, MultLO=0, busy=0, done=0.
//   Reset in RUN/DONE aborts the operation; no done pulse is produced for it.
//  States: IDLE -> RUN on Multstart; RUN -> DONE when count==WIDTH-1 (last step); DONE -> IDLE (always).
//  IDLE + Multstart at edge E0: latch M=Multsrca sign-extended to WIDTH+1, A=0 (WIDTH+1 bits),
//   Q=Multsrcb, q_1=0, count=0. Operands may change after E0.
//  RUN, each edge: per {Q[0],q_1}: 01 -> A=A+M; 10 -> A=A-M; 00/11 -> no op (WIDTH+1-bit arithmetic,
//   wrap discarded); then arithmetic right shift of {A,Q,q_1} by one; count++.
//  A is WIDTH+1 bits so M = -2^(WIDTH-1) (0x80000000) negates without overflow.
//  At the edge that performs step WIDTH (edge E_WIDTH): MultHI<=A[WIDTH-1:0] and MultLO<=Q, both computed
//   after that step's shift; enter DONE.
//  DONE: Multdone=1 for exactly this one cycle (the cycle after edge E_WIDTH); busy still 1.
//  Latency: Multstart sampled at E0 -> Multdone high in cycle after E_WIDTH (WIDTH edges; 32 for default).
//  MultHI/MultLO hold their value until the next completed operation (not cleared by a new start).
//  Multstart while busy (RUN/DONE): ignored, not queued. Multstart in the IDLE cycle following DONE is accepted.
//  Busy is a registered output; Multdone is registered (state==DONE).
//  No overflow/exception output: 2*WIDTH result is always exact.
// STRUCTURE
//  Shared package (mips_pkg): state encoding localparams MUL_IDLE=2'd0, MUL_RUN=2'd1, MUL_DONE=2'd2;
//   default WIDTH; shared with the divider if it is later made sequential.
//  Single module; optional sub-module booth_step (comb: {A,Q,q_1},M -> next {A,Q,q_1}) for unit test.
//  Counter width $clog2(WIDTH).
// TESTING
//  7 x 6: start, wait -> done after 32 edges, HI=0x00000000, LO=0x0000002A, done high exactly 1 cycle.
//  -3 x 5 (0xFFFFFFFD,0x00000005) -> HI=0xFFFFFFFF, LO=0xFFFFFFF1.
//  0x80000000 x 0x80000000 -> HI=0x40000000, LO=0x00000000;
//   0x80000000 x 0x00000001 -> HI=0xFFFFFFFF, LO=0x80000000.
//  0xFFFFFFFF x 0xFFFFFFFF -> HI=0, LO=1; 0x7FFFFFFF x 0x7FFFFFFF -> HI=0x3FFFFFFF, LO=0x00000001.
//  Start pulsed again 5 cycles into RUN with other operands -> ignored; result is of first pair, one done only.
//  reset_n=0 at cycle 10 of RUN -> next cycle busy=0, done=0, HI=LO=0; no done follows.
//   Then new start completes normally.

Source files
------------

// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared datapath constants for the multicycle MIPS arithmetic units
package mips_pkg;

    localparam int MUL_WIDTH = 32;

    localparam logic [1:0] MUL_IDLE = 2'd0;
    localparam logic [1:0] MUL_RUN  = 2'd1;
    localparam logic [1:0] MUL_DONE = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = MUL_IDLE,
        ST_RUN  = MUL_RUN,
        ST_DONE = MUL_DONE
    } mul_state_e;

endpackage

// File: rtl/booth_step.sv
// rtl/booth_step.sv - one radix-2 Booth add/subtract plus arithmetic right shift
module booth_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH:0]   a,
    input  logic [WIDTH-1:0] q,
    input  logic             q_1,
    input  logic [WIDTH:0]   m,
    output logic [WIDTH:0]   a_next,
    output logic [WIDTH-1:0] q_next,
    output logic             q_1_next
);

    logic [WIDTH:0] a_sum;

    always_comb begin
        a_sum = a;
        case ({q[0], q_1})
            2'b01:   a_sum = a + m;
            2'b10:   a_sum = a - m;
            default: a_sum = a;
        endcase
    end

    // Shift {a_sum, q, q_1} right by one, replicating the sign of the accumulator.
    always_comb begin
        a_next   = {a_sum[WIDTH], a_sum[WIDTH:1]};
        q_next   = {a_sum[0], q[WIDTH-1:1]};
        q_1_next = q[0];
    end

endmodule

// File: rtl/mult_seq.sv
// rtl/mult_seq.sv - sequential signed Booth multiplier producing HI/LO for MULT
module mult_seq
    import mips_pkg::*;
#(
    parameter int WIDTH = MUL_WIDTH
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             Multstart,
    input  logic [WIDTH-1:0] Multsrca,
    input  logic [WIDTH-1:0] Multsrcb,
    output logic [WIDTH-1:0] MultHI,
    output logic [WIDTH-1:0] MultLO,
    output logic             Multbusy,
    output logic             Multdone
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

    mul_state_e       state;
    logic [CW-1:0]    count;
    logic [WIDTH:0]   a_reg;
    logic [WIDTH:0]   m_reg;
    logic [WIDTH-1:0] q_reg;
    logic             q_1_reg;

    logic [WIDTH:0]   a_nx;
    logic [WIDTH-1:0] q_nx;
    logic             q_1_nx;

    booth_step #(.WIDTH(WIDTH)) u_step (
        .a        (a_reg),
        .q        (q_reg),
        .q_1      (q_1_reg),
        .m        (m_reg),
        .a_next   (a_nx),
        .q_next   (q_nx),
        .q_1_next (q_1_nx)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state    <= ST_IDLE;
            count    <= '0;
            a_reg    <= '0;
            m_reg    <= '0;
            q_reg    <= '0;
            q_1_reg  <= 1'b0;
            MultHI   <= '0;
            MultLO   <= '0;
            Multbusy <= 1'b0;
            Multdone <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    Multdone <= 1'b0;
                    if (Multstart) begin
                        // Extra accumulator bit lets M = most-negative value be negated exactly.
                        m_reg    <= {Multsrca[WIDTH-1], Multsrca};
                        a_reg    <= '0;
                        q_reg    <= Multsrcb;
                        q_1_reg  <= 1'b0;
                        count    <= '0;
                        Multbusy <= 1'b1;
                        state    <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    a_reg   <= a_nx;
                    q_reg   <= q_nx;
                    q_1_reg <= q_1_nx;
                    count   <= count + CW'(1);
                    if (count == LAST_STEP) begin
                        MultHI   <= a_nx[WIDTH-1:0];
                        MultLO   <= q_nx;
                        Multdone <= 1'b1;
                        state    <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    Multdone <= 1'b0;
                    Multbusy <= 1'b0;
                    state    <= ST_IDLE;
                end
                default: begin
                    Multdone <= 1'b0;
                    Multbusy <= 1'b0;
                    state    <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mult_seq.sv
// tb/tb_mult_seq.sv - directed self-checking bench for mult_seq
module tb_mult_seq;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        Multstart;
    logic [31:0] Multsrca;
    logic [31:0] Multsrcb;
    logic [31:0] MultHI;
    logic [31:0] MultLO;
    logic        Multbusy;
    logic        Multdone;

    int checks = 0;
    int errors = 0;

    mult_seq dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .Multstart (Multstart),
        .Multsrca  (Multsrca),
        .Multsrcb  (Multsrcb),
        .MultHI    (MultHI),
        .MultLO    (MultLO),
        .Multbusy  (Multbusy),
        .Multdone  (Multdone)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Pulse start for one edge; returns at the negedge after that edge (E0).
    task automatic start_op(input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        Multsrca  = a;
        Multsrcb  = b;
        Multstart = 1'b1;
        @(negedge clk);
        Multstart = 1'b0;
        Multsrca  = $urandom;
        Multsrcb  = $urandom;
    endtask

    // Counts edges after E0 until done is seen; bounded.
    task automatic wait_done(input string tag, output int edges);
        edges = 0;
        while (!Multdone && edges < 100) begin
            @(negedge clk);
            edges++;
        end
        check({tag, "_seen"}, {63'd0, Multdone}, 64'd1);
    endtask

    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic [63:0] exp);
        int lat;
        start_op(a, b);
        check({tag, "_busy"}, {63'd0, Multbusy}, 64'd1);
        wait_done(tag, lat);
        check({tag, "_lat"}, 64'(lat), 64'd32);
        check({tag, "_prod"}, {MultHI, MultLO}, exp);
        @(negedge clk);
        check({tag, "_done1"}, {63'd0, Multdone}, 64'd0);
        check({tag, "_idle"}, {63'd0, Multbusy}, 64'd0);
    endtask

    task automatic count_dones(input int cycles, output int n);
        n = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (Multdone) n++;
        end
    endtask

    initial begin
        int lat;
        int n;
        reset_n   = 1'b0;
        Multstart = 1'b0;
        Multsrca  = '0;
        Multsrcb  = '0;
        repeat (3) @(negedge clk);
        check("rst_hi_lo", {MultHI, MultLO}, 64'd0);
        check("rst_busy", {63'd0, Multbusy}, 64'd0);
        check("rst_done", {63'd0, Multdone}, 64'd0);
        reset_n = 1'b1;

        run_op("7x6",     32'h0000_0007, 32'h0000_0006, 64'h00000000_0000002A);
        run_op("m3x5",    32'hFFFF_FFFD, 32'h0000_0005, 64'hFFFFFFFF_FFFFFFF1);
        run_op("minxmin", 32'h8000_0000, 32'h8000_0000, 64'h40000000_00000000);
        run_op("minx1",   32'h8000_0000, 32'h0000_0001, 64'hFFFFFFFF_80000000);
        run_op("1xmin",   32'h0000_0001, 32'h8000_0000, 64'hFFFFFFFF_80000000);
        run_op("m1xm1",   32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h00000000_00000001);
        run_op("maxxmax", 32'h7FFF_FFFF, 32'h7FFF_FFFF, 64'h3FFFFFFF_00000001);

        // Back-to-back: start in the IDLE cycle right after DONE (run_op returns there).
        start_op(32'h0000_0003, 32'hFFFF_FFFE);
        repeat (4) @(negedge clk);
        check("hold_prev", {MultHI, MultLO}, 64'h3FFFFFFF_00000001);
        Multsrca  = 32'h0000_1234;
        Multsrcb  = 32'h0000_5678;
        Multstart = 1'b1;
        @(negedge clk);
        Multstart = 1'b0;
        lat = 0;
        wait_done("ign", lat);
        check("ign_lat", 64'(lat + 5), 64'd32);
        check("ign_prod", {MultHI, MultLO}, 64'hFFFFFFFF_FFFFFFFA);
        count_dones(45, n);
        check("ign_extra_done", 64'(n), 64'd0);

        // Abort with reset mid-run.
        start_op(32'h0000_0009, 32'h0000_0009);
        repeat (9) @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        check("abort_busy", {63'd0, Multbusy}, 64'd0);
        check("abort_done", {63'd0, Multdone}, 64'd0);
        check("abort_hi_lo", {MultHI, MultLO}, 64'd0);
        count_dones(45, n);
        check("abort_no_done", 64'(n), 64'd0);

        run_op("post_rst", 32'h0001_0000, 32'hFFFF_0000, 64'hFFFFFFFF_00000000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
